// File: rtl/reg_write_arbiter_pkg.sv
// reg_arb_pkg: shared definitions for the register write arbiter.
//   - DEF_DATA_W / DEF_N_REQ : default register width and requester count
//   - MAX_REQ                : widest requester vector the pick function handles
//   - state_e                : arbiter FSM states
//   - rr_pick()              : round-robin winner search starting at a pointer
package reg_arb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_N_REQ  = 4;
   localparam int MAX_REQ    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WRITE = 2'd2,
      ST_ACK   = 2'd3
   } state_e;

   // Scan req_i[ptr_i], req_i[ptr_i+1], ... modulo n_i; the first set bit wins.
   // Returns 0 when nothing is set; callers only use the result when req is nonzero.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req_i,
                                  input int                 ptr_i,
                                  input int                 n_i);
      int   idx;
      int   win;
      logic found;
      win   = 0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n_i) begin
            idx = ptr_i + k;
            if (idx >= n_i) begin
               idx = idx - n_i;
            end else begin
               idx = idx;
            end
            if (!found && req_i[idx]) begin
               win   = idx;
               found = 1'b1;
            end else begin
               found = found;
            end
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side bus of the register write arbiter.
//   req   : per-requester level write request
//   wdata : packed write data, lane i = wdata[i*DATA_W +: DATA_W]
//   gnt   : one-hot registered grant
//   ack   : one-hot single-cycle write-complete pulse
//   q/qn  : shared register value and its bitwise inverse
//   busy  : arbiter is not idle
// master = requester side (testbench), slave = arbiter side.
interface reg_write_arbiter_if
   import reg_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_REQ  = DEF_N_REQ
);

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] wdata;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        ack;
   logic [DATA_W-1:0]       q;
   logic [DATA_W-1:0]       qn;
   logic                    busy;

   modport master (
      output req, wdata,
      input  gnt, ack, q, qn, busy
   );

   modport slave (
      input  req, wdata,
      output gnt, ack, q, qn, busy
   );

endinterface

// File: rtl/reg_write_arbiter_en_dff_reg.sv
// en_dff_reg: DATA_W-wide register with load enable and complementary outputs.
//   clk, rst : clock, asynchronous active-high reset (q=0, qn=all ones)
//   load_i   : capture d_i at the next rising edge
//   d_i      : data in
//   q_o/qn_o : stored value and its inverse, both straight from flops
module en_dff_reg
   import reg_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o,
   output logic [DATA_W-1:0] qn_o
);

   logic [DATA_W-1:0] q_q;
   logic [DATA_W-1:0] qn_q;

   // Data and inverse-data flops; the inverse is stored so qn never glitches against q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q  <= '0;
         qn_q <= '1;
      end else if (load_i) begin
         q_q  <= d_i;
         qn_q <= ~d_i;
      end else begin
         q_q  <= q_q;
         qn_q <= qn_q;
      end
   end

   assign q_o  = q_q;
   assign qn_o = qn_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter granting N_REQ requesters write access
// to one shared DATA_W register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of reg_write_arbiter_if (req/wdata in; gnt/ack/q/qn/busy out)
// A transaction is IDLE -> GRANT -> WRITE -> ACK -> IDLE; dropping req in GRANT
// aborts it without touching the register or the priority pointer.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_REQ  = DEF_N_REQ
) (
   input  logic                 clk,
   input  logic                 rst,
   reg_write_arbiter_if.slave   bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q,   gnt_d;
   logic [N_REQ-1:0]   ack_q,   ack_d;
   logic [IDX_W-1:0]   ptr_q,   ptr_d;
   logic [IDX_W-1:0]   win_q,   win_d;
   logic               busy_q,  busy_d;

   logic [MAX_REQ-1:0] req_ext_s;
   logic [DATA_W-1:0]  lane_s;
   logic               load_s;
   logic [DATA_W-1:0]  q_s;
   logic [DATA_W-1:0]  qn_s;

   // Zero-extend the request vector to the width the pick function scans.
   always_comb begin
      req_ext_s              = '0;
      req_ext_s[N_REQ-1:0]   = bus.req;
   end

   assign lane_s = bus.wdata[int'(win_q)*DATA_W +: DATA_W];
   assign load_s = (state_q == ST_WRITE);

   // Next-state, grant, ack and pointer logic.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      ptr_d   = ptr_q;
      win_d   = win_q;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               win_d        = IDX_W'(rr_pick(req_ext_s, int'(ptr_q), N_REQ));
               gnt_d        = '0;
               gnt_d[win_d] = 1'b1;
               state_d      = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // Winner must still want the slot; otherwise abort with no side effects.
            if (bus.req[win_q]) begin
               state_d = ST_WRITE;
            end else begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            // Register loads at the end of this cycle; ack lines up with the new q.
            ack_d   = gnt_q;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
            if (win_q == IDX_W'(N_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = win_q + IDX_W'(1);
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ack_q   <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         busy_q  <= busy_d;
      end
   end

   en_dff_reg #(.DATA_W(DATA_W)) u_reg (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_s),
      .d_i    (lane_s),
      .q_o    (q_s),
      .qn_o   (qn_s)
   );

   assign bus.gnt  = gnt_q;
   assign bus.ack  = ack_q;
   assign bus.q    = q_s;
   assign bus.qn   = qn_s;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: self-checking bench for reg_write_arbiter.
// Directed table of single transactions, hand-written multi-cycle sequences
// (fairness, abort, reset mid-write) and a randomized run against a
// transaction-level reference model.
module tb_reg_write_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst;

   reg_write_arbiter_if #(.DATA_W(DW), .N_REQ(NR)) bus ();

   reg_write_arbiter #(.DATA_W(DW), .N_REQ(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] lane [NR];

   // reference model: cycle within current transaction (0 = none), winner, pointer, register
   int            m_age;
   int            m_win;
   int            m_ptr;
   logic [DW-1:0] m_q;

   typedef struct {
      logic [NR-1:0] req;
      logic [DW-1:0] base;
      logic [NR-1:0] exp_ack;
      logic [DW-1:0] exp_q;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_lanes();
      for (int i = 0; i < NR; i++) bus.wdata[i*DW +: DW] = lane[i];
   endtask

   task automatic fill_lanes(input logic [DW-1:0] base);
      for (int i = 0; i < NR; i++) lane[i] = base + DW'(i);
      set_lanes();
   endtask

   function automatic int rr_ref(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         if (r[(p + k) % NR]) return (p + k) % NR;
      end
      return 0;
   endfunction

   // advance the model by one rising edge using the inputs present at that edge
   task automatic model_step();
      case (m_age)
         0: if (bus.req != '0) begin m_win = rr_ref(bus.req, m_ptr); m_age = 1; end
         1: m_age = bus.req[m_win] ? 2 : 0;
         2: begin m_q = lane[m_win]; m_age = 3; end
         default: begin m_ptr = (m_win + 1) % NR; m_age = 0; end
      endcase
   endtask

   task automatic check_model();
      logic [NR-1:0] eg;
      logic [NR-1:0] ea;
      eg = (m_age != 0) ? NR'(1 << m_win) : '0;
      ea = (m_age == 3) ? NR'(1 << m_win) : '0;
      chk("rnd_gnt",  DW'(bus.gnt), DW'(eg));
      chk("rnd_ack",  DW'(bus.ack), DW'(ea));
      chk("rnd_busy", DW'(bus.busy), DW'(m_age != 0));
      chk("rnd_q",    bus.q, m_q);
      chk("rnd_qn",   bus.qn, ~bus.q);
      chk("rnd_gnt_onehot0", DW'($onehot0(bus.gnt)), 32'd1);
      chk("rnd_ack_onehot0", DW'($onehot0(bus.ack)), 32'd1);
   endtask

   // one full transaction from IDLE, checked cycle by cycle
   task automatic run_txn(input logic [NR-1:0] r, input logic [DW-1:0] base,
                          input logic [NR-1:0] exp_oh, input logic [DW-1:0] old_q,
                          input logic [DW-1:0] exp_q);
      fill_lanes(base);
      bus.req = r;
      @(posedge clk); #1;
      chk("txn_c1_gnt", DW'(bus.gnt), DW'(exp_oh));
      chk("txn_c1_ack", DW'(bus.ack), 32'd0);
      chk("txn_c1_busy", DW'(bus.busy), 32'd1);
      @(posedge clk); #1;
      chk("txn_c2_gnt", DW'(bus.gnt), DW'(exp_oh));
      chk("txn_c2_ack", DW'(bus.ack), 32'd0);
      chk("txn_c2_q", bus.q, old_q);
      @(posedge clk); #1;
      chk("txn_c3_gnt", DW'(bus.gnt), DW'(exp_oh));
      chk("txn_c3_ack", DW'(bus.ack), DW'(exp_oh));
      chk("txn_c3_q", bus.q, exp_q);
      chk("txn_c3_qn", bus.qn, ~exp_q);
      bus.req = '0;
      @(posedge clk); #1;
      chk("txn_c4_busy", DW'(bus.busy), 32'd0);
      chk("txn_c4_gnt", DW'(bus.gnt), 32'd0);
      chk("txn_c4_ack", DW'(bus.ack), 32'd0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      chk("rst_q", bus.q, 32'h0);
      chk("rst_qn", bus.qn, 32'hFFFF_FFFF);
      chk("rst_busy", DW'(bus.busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] last_q;
      int            cnt;
      logic          seen;

      vecs[0] = '{4'b0001, 32'hDEAD_BEEF, 4'b0001, 32'hDEAD_BEEF};
      vecs[1] = '{4'b0101, 32'h1000_0000, 4'b0100, 32'h1000_0002};
      vecs[2] = '{4'b1001, 32'h2000_0000, 4'b1000, 32'h2000_0003};
      vecs[3] = '{4'b1001, 32'h3000_0000, 4'b0001, 32'h3000_0000};
      vecs[4] = '{4'b1000, 32'h4000_0000, 4'b1000, 32'h4000_0003};
      vecs[5] = '{4'b0110, 32'h5000_0000, 4'b0010, 32'h5000_0001};

      // reset state before any clock edge
      rst     = 1'b1;
      bus.req = '0;
      fill_lanes(32'h0);
      #2;
      chk("reset_gnt", DW'(bus.gnt), 32'd0);
      chk("reset_ack", DW'(bus.ack), 32'd0);
      chk("reset_q", bus.q, 32'h0);
      chk("reset_qn", bus.qn, 32'hFFFF_FFFF);
      chk("reset_busy", DW'(bus.busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed table: pointer evolves 0 ->1 ->3 ->0 ->1 ->0 ->2
      last_q = 32'h0;
      for (int v = 0; v < 6; v++) begin
         run_txn(vecs[v].req, vecs[v].base, vecs[v].exp_ack, last_q, vecs[v].exp_q);
         last_q = vecs[v].exp_q;
      end

      // fairness: all four held from pointer 0
      pulse_reset();
      fill_lanes(32'h0);
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         cnt  = 0;
         seen = 1'b0;
         while (!seen && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
            seen = (bus.ack != '0);
         end
         if (!seen) begin
            total++; bad++;
            $display("FAIL fair_timeout: got no ack expected ack %0d", n % NR);
         end else begin
            chk("fair_ack", DW'(bus.ack), DW'(1 << (n % NR)));
            chk("fair_q", bus.q, DW'(n % NR));
            chk("fair_gap", DW'(cnt), (n == 0) ? 32'd3 : 32'd4);
         end
      end
      bus.req = '0;
      @(posedge clk); #1;
      chk("fair_idle_busy", DW'(bus.busy), 32'd0);

      // abort: requester 1 drops req while in GRANT; pointer stays 1
      lane[1] = 32'hBAD0_0001;
      set_lanes();
      bus.req = 4'b0010;
      @(posedge clk); #1;
      chk("abort_gnt", DW'(bus.gnt), 32'd2);
      bus.req = '0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("abort_gnt_clr", DW'(bus.gnt), 32'd0);
         chk("abort_ack", DW'(bus.ack), 32'd0);
         chk("abort_busy", DW'(bus.busy), 32'd0);
         chk("abort_q", bus.q, 32'h0);
      end
      run_txn(4'b0011, 32'h6000_0000, 4'b0010, 32'h0, 32'h6000_0001);

      // reset in the WRITE cycle: pointer is 2 here, must be 0 afterwards
      fill_lanes(32'h7000_0000);
      bus.req = 4'b0100;
      @(posedge clk); #1;
      chk("rstw_gnt", DW'(bus.gnt), 32'd4);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rstw_q", bus.q, 32'h0);
      chk("rstw_qn", bus.qn, 32'hFFFF_FFFF);
      chk("rstw_gnt0", DW'(bus.gnt), 32'd0);
      chk("rstw_ack0", DW'(bus.ack), 32'd0);
      chk("rstw_busy", DW'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk("rstw_ack_hold", DW'(bus.ack), 32'd0);
      chk("rstw_q_hold", bus.q, 32'h0);
      bus.req = 4'b0101;
      rst     = 1'b0;
      @(posedge clk); #1;
      chk("rstw_first_gnt", DW'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rstw_ack", DW'(bus.ack), 32'd1);
      chk("rstw_newq", bus.q, 32'h7000_0000);
      bus.req = '0;
      @(posedge clk); #1;

      // randomized run against the model
      pulse_reset();
      m_age = 0; m_win = 0; m_ptr = 0; m_q = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) bus.req = NR'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++) begin
            if (!((m_age == 1 || m_age == 2) && i == m_win) && $urandom_range(0, 1) == 1)
               lane[i] = $urandom;
         end
         set_lanes();
         @(posedge clk);
         model_step();
         #1;
         check_model();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of the shared register and every write-data lane.
REQ-002 Parameter N_REQ, default 4: number of requesters; index width is clog2(N_REQ).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester write request, level-sensitive.
REQ-006 wdata  input  N_REQ*DATA_W  packed write data; lane i is bits [i*DATA_W +: DATA_W].
REQ-007 gnt  output  N_REQ  one-hot registered grant; zero when no grant is held.
REQ-008 ack  output  N_REQ  one-hot, single-cycle write-complete pulse.
REQ-009 q  output  DATA_W  current shared register value.
REQ-010 qn  output  DATA_W  bitwise inverse of q at all times.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, GRANT, WRITE, ACK; state is registered.
REQ-013 IDLE: if req is nonzero, select the winner round-robin from priority pointer ptr, register gnt = onehot(winner), and go to GRANT; otherwise stay in IDLE.
REQ-014 Round-robin order: search req[ptr], req[ptr+1], ... modulo N_REQ; the first set bit wins.
REQ-015 GRANT: if req[winner] is still high, go to WRITE; otherwise clear gnt and return to IDLE with no write, no ack, and ptr unchanged (abort).
REQ-016 WRITE: assert the internal load enable for exactly one cycle; the register captures wdata lane [winner] at the end of that cycle.
REQ-017 ACK: ack[winner] = 1 for exactly this cycle, q already holds the new value, ptr <= (winner+1) mod N_REQ, gnt cleared on exit; next state is IDLE.
REQ-018 Latency: req first seen high in IDLE at cycle 0 gives gnt high in cycles 1-3, the load in cycle 2, and q plus ack valid in cycle 3; the earliest next grant is cycle 5.
REQ-019 The requester must hold req and its wdata lane stable from gnt high until ack; wdata is sampled only in WRITE.
REQ-020 req changes in WRITE or ACK do not cancel the write in progress.
REQ-021 Requests arriving in any state other than IDLE are not lost; they stay pending while req is held and are arbitrated on the next IDLE.
REQ-022 q changes only on a WRITE cycle or on reset; it holds its value in all other states.
REQ-023 ack and gnt are never nonzero for more than one requester in the same cycle.

Reset
REQ-024 While rst is high, independent of clk: state = IDLE, gnt = 0, ack = 0, ptr = 0, q = 0, qn = all ones, busy = 0.
REQ-025 rst asserted mid-transaction aborts it without an ack; a write not yet captured is discarded.
REQ-026 The first rising clk edge after rst deasserts evaluates IDLE normally.

Structure
REQ-027 Package reg_arb_pkg holds the FSM state enum, the default DATA_W/N_REQ constants, and the round-robin pick function.
REQ-028 Sub-module en_dff_reg holds the DATA_W-wide register: async active-high reset, load enable, and q/qn outputs; it is instantiated once.
REQ-029 Arbiter, FSM and pointer logic live in reg_write_arbiter; the target implementation is 120-400 lines of RTL.

Verification
REQ-030 Single request: req=4'b0001, lane0=32'hDEADBEEF at cycle 0 -> gnt=0001 in cycles 1-3, q=DEADBEEF and qn=21524110 with ack=0001 in cycle 3, busy=0 in cycle 4.
REQ-031 Fairness: req=4'b1111 held, lanes = 32'h0..32'h3 -> ack order 0,1,2,3,0, with q following 0,1,2,3,0.
REQ-032 Pointer wrap: ptr=3 after a grant to requester 2, req=4'b1001 -> requester 3 wins, then requester 0.
REQ-033 Abort: req=4'b0010 for one cycle only (dropped in GRANT) -> no ack, q unchanged, back to IDLE, ptr unchanged.
REQ-034 Reset mid-write: rst pulsed during WRITE -> q=0, qn=32'hFFFFFFFF, gnt=0, ack never asserted, ptr=0 immediately, without waiting for a clock edge.
REQ-035 Every cycle, assert $onehot0(gnt), $onehot0(ack) and qn == ~q.
